// File: rtl/cmp_result_tracker.sv
// cmp_result_tracker: tracks the results of an upstream X/Y comparator.
// It keeps a saturating event counter for each of GT, LT and EQ, and runs an
// FSM that follows the current run of identical results. streak is raised
// during a long GT or LT run.
// Optional feature: define CMP_RESULT_TRACKER_ERR_CHECK_EN to enable
// illegal-flag detection. When it is defined, err is sticky and illegal
// samples are dropped. When it is undefined, the flags are priority-decoded
// and err is tied low.
module cmp_result_tracker #(
    parameter int unsigned CNT_W  = 4,
    parameter int unsigned RUN_TH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             xgty,
    input  logic             xlty,
    input  logic             xeqy,
    input  logic             clr,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [1:0]       state,
    output logic [2:0]       run_len,
    output logic             streak,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GT_RUN = 2'b01,
        LT_RUN = 2'b10,
        EQ_RUN = 2'b11
    } state_t;

    state_t st;
    state_t tgt;
    logic   hit;

`ifdef CMP_RESULT_TRACKER_ERR_CHECK_EN
    logic bad;
    logic err_q;

    // Decode a sample: exactly one flag must be set, anything else is illegal
    always_comb begin
        hit = 1'b0;
        bad = 1'b0;
        tgt = IDLE;
        case ({xgty, xlty, xeqy})
            3'b100:  begin hit = 1'b1; tgt = GT_RUN; end
            3'b010:  begin hit = 1'b1; tgt = LT_RUN; end
            3'b001:  begin hit = 1'b1; tgt = EQ_RUN; end
            default: bad = 1'b1;
        endcase
    end

    // Sticky illegal-sample flag, cleared only by rst or clr
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            err_q <= 1'b0;
        end else if (in_valid && bad) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    // Decode a sample by priority xgty > xlty > xeqy; all-zero is no hit
    always_comb begin
        hit = 1'b0;
        tgt = IDLE;
        if (xgty) begin
            hit = 1'b1;
            tgt = GT_RUN;
        end else if (xlty) begin
            hit = 1'b1;
            tgt = LT_RUN;
        end else if (xeqy) begin
            hit = 1'b1;
            tgt = EQ_RUN;
        end
    end

    assign err = 1'b0;
`endif

    // Counters, run FSM and run length, all advanced only by an accepted legal sample
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            gt_cnt  <= '0;
            lt_cnt  <= '0;
            eq_cnt  <= '0;
            st      <= IDLE;
            run_len <= '0;
        end else if (in_valid && hit) begin
            case (tgt)
                GT_RUN:  if (gt_cnt != '1) gt_cnt <= gt_cnt + CNT_W'(1);
                LT_RUN:  if (lt_cnt != '1) lt_cnt <= lt_cnt + CNT_W'(1);
                EQ_RUN:  if (eq_cnt != '1) eq_cnt <= eq_cnt + CNT_W'(1);
                default: ;
            endcase
            if (st == tgt) begin
                if (run_len != 3'd7) run_len <= run_len + 3'd1;
            end else begin
                st      <= tgt;
                run_len <= 3'd1;
            end
        end
    end

    assign state  = st;
    assign streak = ((st == GT_RUN) || (st == LT_RUN)) && (32'(run_len) >= RUN_TH);

endmodule

// File: tb/tb_cmp_result_tracker.sv
// Scoreboard bench for cmp_result_tracker. Each driven cycle pushes its
// hand-computed expected outputs into a queue. A monitor pops one entry after
// every rising edge and compares it against the DUT.
module tb_cmp_result_tracker;

    logic       clk = 1'b0;
    logic       rst, in_valid, xgty, xlty, xeqy, clr;
    logic [3:0] gt_cnt, lt_cnt, eq_cnt;
    logic [1:0] state;
    logic [2:0] run_len;
    logic       streak, err;

    typedef struct {
        bit chk;
        int gc, lc, ec, st, rl, sk, er;
    } exp_t;

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    cmp_result_tracker #(.CNT_W(4), .RUN_TH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .xgty(xgty), .xlty(xlty),
        .xeqy(xeqy), .clr(clr), .gt_cnt(gt_cnt), .lt_cnt(lt_cnt),
        .eq_cnt(eq_cnt), .state(state), .run_len(run_len), .streak(streak),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: one expectation per clock, compared #1 after the rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                if (e.chk) begin
                    chk1("gt_cnt",  int'(gt_cnt),  e.gc);
                    chk1("lt_cnt",  int'(lt_cnt),  e.lc);
                    chk1("eq_cnt",  int'(eq_cnt),  e.ec);
                    chk1("state",   int'(state),   e.st);
                    chk1("run_len", int'(run_len), e.rl);
                    chk1("streak",  int'(streak),  e.sk);
                    chk1("err",     int'(err),     e.er);
                end
            end
        end
    end

    task automatic drive(input logic r, input logic c, input logic v,
                         input logic g, input logic l, input logic e, input exp_t x);
        @(negedge clk);
        rst = r; clr = c; in_valid = v; xgty = g; xlty = l; xeqy = e;
        q.push_back(x);
    endtask

    // Unchecked cycle
    task automatic cyc(input logic r, input logic c, input logic v,
                       input logic g, input logic l, input logic e);
        exp_t x;
        x = '{0, 0, 0, 0, 0, 0, 0, 0};
        drive(r, c, v, g, l, e, x);
    endtask

    // Checked cycle: expected outputs after this cycle's rising edge
    task automatic cycx(input logic r, input logic c, input logic v,
                        input logic g, input logic l, input logic e,
                        input int gc, input int lc, input int ec,
                        input int st, input int rl, input int sk, input int er);
        exp_t x;
        x = '{1, gc, lc, ec, st, rl, sk, er};
        drive(r, c, v, g, l, e, x);
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; xgty = 1'b0; xlty = 1'b0; xeqy = 1'b0;

        // Reset state, including rst taking priority over clr and a valid sample
        cycx(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        cycx(1, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0);

        // Five GT samples: streak from the 4th onward
        cycx(0, 0, 1, 1, 0, 0,  1, 0, 0, 1, 1, 0, 0);
        cycx(0, 0, 1, 1, 0, 0,  2, 0, 0, 1, 2, 0, 0);
        cycx(0, 0, 1, 1, 0, 0,  3, 0, 0, 1, 3, 0, 0);
        cycx(0, 0, 1, 1, 0, 0,  4, 0, 0, 1, 4, 1, 0);
        cycx(0, 0, 1, 1, 0, 0,  5, 0, 0, 1, 5, 1, 0);

        // GT, GT, LT, EQ, EQ, then an invalid cycle that must change nothing
        cycx(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        cycx(0, 0, 1, 1, 0, 0,  1, 0, 0, 1, 1, 0, 0);
        cycx(0, 0, 1, 1, 0, 0,  2, 0, 0, 1, 2, 0, 0);
        cycx(0, 0, 1, 0, 1, 0,  2, 1, 0, 2, 1, 0, 0);
        cycx(0, 0, 1, 0, 0, 1,  2, 1, 1, 3, 1, 0, 0);
        cycx(0, 0, 1, 0, 0, 1,  2, 1, 2, 3, 2, 0, 0);
        cycx(0, 0, 0, 1, 1, 0,  2, 1, 2, 3, 2, 0, 0);

        // 20 EQ samples: eq_cnt saturates at 15, run_len at 7, streak stays 0
        cycx(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 20; k++)
            cycx(0, 0, 1, 0, 0, 1,  0, 0, (k > 15) ? 15 : k, 3, (k > 7) ? 7 : k, 0, 0);
        // Saturated eq_cnt leaves the FSM and the other counters working
        cycx(0, 0, 1, 1, 0, 0,  1, 0, 15, 1, 1, 0, 0);
        cycx(0, 0, 1, 0, 1, 0,  1, 1, 15, 2, 1, 0, 0);

        // Three LT samples, then clr with a valid GT discards the sample
        cycx(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        cycx(0, 0, 1, 0, 1, 0,  0, 1, 0, 2, 1, 0, 0);
        cycx(0, 0, 1, 0, 1, 0,  0, 2, 0, 2, 2, 0, 0);
        cycx(0, 0, 1, 0, 1, 0,  0, 3, 0, 2, 3, 0, 0);
        cycx(0, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        cycx(0, 0, 1, 1, 0, 0,  1, 0, 0, 1, 1, 0, 0);
        // A four-long LT run raises streak
        cycx(0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        cycx(0, 0, 1, 0, 1, 0,  0, 1, 0, 2, 1, 0, 0);
        cycx(0, 0, 1, 0, 1, 0,  0, 2, 0, 2, 2, 0, 0);
        cycx(0, 0, 1, 0, 1, 0,  0, 3, 0, 2, 3, 0, 0);
        cycx(0, 0, 1, 0, 1, 0,  0, 4, 0, 2, 4, 1, 0);

        // rst mid-run with a valid sample; tracking restarts from IDLE
        cycx(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        cyc (0, 0, 1, 1, 0, 0);
        cyc (0, 0, 1, 1, 0, 0);
        cycx(0, 0, 1, 1, 0, 0,  3, 0, 0, 1, 3, 0, 0);
        cycx(1, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        cycx(0, 0, 1, 0, 1, 0,  0, 1, 0, 2, 1, 0, 0);

`ifdef CMP_RESULT_TRACKER_ERR_CHECK_EN
        // Illegal samples set sticky err and change nothing else
        cycx(0, 0, 1, 1, 1, 0,  0, 1, 0, 2, 1, 0, 1);
        cycx(0, 0, 1, 0, 0, 0,  0, 1, 0, 2, 1, 0, 1);
        cycx(0, 0, 1, 0, 1, 0,  0, 2, 0, 2, 2, 0, 1);
        cycx(0, 0, 0, 1, 1, 1,  0, 2, 0, 2, 2, 0, 1);
        cycx(0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        cycx(0, 0, 1, 1, 1, 1,  0, 0, 0, 0, 0, 0, 1);
        cycx(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
`else
        // Priority decode: GT beats LT, LT beats EQ, all-zero is ignored
        cycx(0, 0, 1, 1, 1, 0,  1, 1, 0, 1, 1, 0, 0);
        cycx(0, 0, 1, 0, 1, 1,  1, 2, 0, 2, 1, 0, 0);
        cycx(0, 0, 1, 0, 0, 0,  1, 2, 0, 2, 1, 0, 0);
        cycx(0, 0, 1, 1, 1, 1,  2, 2, 0, 1, 1, 0, 0);
        cycx(0, 0, 1, 0, 0, 1,  2, 2, 1, 3, 1, 0, 0);
`endif

        // Drain the scoreboard within a bounded number of cycles
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        n_total++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d entries left expected 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
